// File: rtl/prince_a6_inv_share_serial.sv
// prince_a6_inv_share_serial
// Serial inverse of the share-1 A6 nibble map for the threshold-implemented
// PRINCE datapath. One 64-bit share word is captured, then its 16 nibbles are
// inverse-mapped one per clock (nibble 0 first). The result is offered on a
// valid/ready output handshake.
//
// Optional feature macro: PRINCE_A6_INV_SELFCHECK_EN
//   When defined, a copy of the captured word is kept. On completion the
//   forward A6 map is re-applied to the result and compared with the copy.
//   The outcome drives chk_err during DONE. When undefined, chk_err is 0.
module prince_a6_inv_share_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        chk_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  idx_r;
   logic [63:0] work_r;
   logic        in_ready_r;
   logic        out_valid_r;
   logic [63:0] run_word_s;
   logic        last_nibble_s;

   // Inverse share-1 A6 map on one nibble: y -> x.
   function automatic logic [3:0] a6_inv_nibble(input logic [3:0] y);
      logic [3:0] x;
      x[3] = 1'b1 ^ y[3] ^ y[1];
      x[2] = y[2];
      x[1] = 1'b1 ^ y[0];
      x[0] = y[1];
      return x;
   endfunction

   // Working word with the current nibble replaced by its inverse-mapped value.
   always_comb begin
      run_word_s                        = work_r;
      run_word_s[{idx_r, 2'b00} +: 4]   = a6_inv_nibble(work_r[{idx_r, 2'b00} +: 4]);
      if (idx_r == 4'd15) begin
         last_nibble_s = 1'b1;
      end else begin
         last_nibble_s = 1'b0;
      end
   end

   // Control FSM: capture in IDLE, one nibble per cycle in RUN, hold result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= 4'd0;
         work_r      <= 64'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  work_r     <= in_data;
                  idx_r      <= 4'd0;
                  in_ready_r <= 1'b0;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               work_r <= run_word_s;
               idx_r  <= idx_r + 4'd1;
               if (last_nibble_s) begin
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               // A pending in_valid here is deliberately not taken; the next
               // word can only be accepted once back in IDLE.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               idx_r       <= 4'd0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   // Continuous view of the working register; meaningful only while out_valid.
   assign out_data  = work_r;

`ifdef PRINCE_A6_INV_SELFCHECK_EN
   logic [63:0] copy_r;
   logic        chk_err_r;

   // Forward share-1 A6 map on one nibble: x -> y.
   function automatic logic [3:0] a6_fwd_nibble(input logic [3:0] x);
      logic [3:0] y;
      y[3] = 1'b1 ^ x[3] ^ x[0];
      y[2] = x[2];
      y[1] = x[0];
      y[0] = 1'b1 ^ x[1];
      return y;
   endfunction

   // Forward map applied to all 16 nibbles of a word.
   function automatic logic [63:0] a6_fwd_word(input logic [63:0] w);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = a6_fwd_nibble(w[4*i +: 4]);
      end
      return r;
   endfunction

   // Keep the captured word and compare it with the re-mapped result on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         copy_r    <= 64'd0;
         chk_err_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               chk_err_r <= 1'b0;
               if (in_valid && in_ready_r) begin
                  copy_r <= in_data;
               end
            end
            RUN: begin
               if (last_nibble_s) begin
                  chk_err_r <= (a6_fwd_word(run_word_s) != copy_r);
               end
            end
            DONE: begin
               if (out_ready) begin
                  chk_err_r <= 1'b0;
               end
            end
            default: begin
               chk_err_r <= 1'b0;
            end
         endcase
      end
   end

   assign chk_err = chk_err_r;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_prince_a6_inv_share_serial.sv
// Directed self-checking bench for prince_a6_inv_share_serial.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_prince_a6_inv_share_serial;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        chk_err;

   int tests;
   int fails;

   prince_a6_inv_share_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .chk_err   (chk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance cycle by cycle until out_valid rises; count cycles, bounded at 40.
   task automatic wait_out(output int cnt);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   task automatic test_reset();
      int cnt;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 64'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      tests++; if (out_data !== 64'd0) begin fails++; $display("FAIL rst_out_data got %h want 0", out_data); end
      tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL rst_chk_err got %b want 0", chk_err); end
      // release with a word already offered
      in_valid  = 1'b1;
      in_data   = 64'd0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0) begin
         fails++; $display("FAIL rel_outputs got rdy=%b vld=%b data=%h want 1 0 0", in_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_accept_ready got %b want 0", in_ready); end
      wait_out(cnt);
      tests++; if (cnt != 16) begin fails++; $display("FAIL rst_latency got %0d want 16", cnt); end
      tests++; if (out_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin fails++; $display("FAIL rst_zero_word got %h want aaaaaaaaaaaaaaaa", out_data); end
      tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL rst_chk_err_done got %b want 0", chk_err); end
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL rst_back_idle got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_mixed();
      logic [63:0] vin [2];
      logic [63:0] vexp [2];
      int cnt;
      vin[0] = 64'hFFFF_FFFF_FFFF_FFFF; vexp[0] = 64'hDDDD_DDDD_DDDD_DDDD;
      vin[1] = 64'h0000_0000_0000_0021; vexp[1] = 64'hAAAA_AAAA_AAAA_AA38;
      for (int i = 0; i < 2; i++) begin
         in_data   = vin[i];
         in_valid  = 1'b1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         wait_out(cnt);
         tests++; if (cnt != 16) begin fails++; $display("FAIL mixed%0d_latency got %0d want 16", i, cnt); end
         tests++; if (out_data !== vexp[i]) begin fails++; $display("FAIL mixed%0d_data got %h want %h", i, out_data, vexp[i]); end
         tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL mixed%0d_chk_err got %b want 0", i, chk_err); end
         @(posedge clk);
         #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mixed%0d_idle got %b want 1", i, in_ready); end
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      // a second word stays offered through RUN and DONE
      in_data = 64'h0000_0000_0000_0021;
      wait_out(cnt);
      tests++; if (cnt != 16) begin fails++; $display("FAIL bp_latency got %0d want 16", cnt); end
      tests++; if (out_data !== 64'hDDDD_DDDD_DDDD_DDDD) begin fails++; $display("FAIL bp_data got %h want dddddddddddddddd", out_data); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'hDDDD_DDDD_DDDD_DDDD) begin
            fails++; $display("FAIL bp_hold%0d got vld=%b rdy=%b data=%h want 1 0 dddddddddddddddd", i, out_valid, in_ready, out_data);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_next_accept got %b want 0", in_ready); end
      wait_out(cnt);
      tests++; if (cnt != 16) begin fails++; $display("FAIL bp_next_latency got %0d want 16", cnt); end
      tests++; if (out_data !== 64'hAAAA_AAAA_AAAA_AA38) begin fails++; $display("FAIL bp_next_data got %h want aaaaaaaaaaaaaa38", out_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run();
      int cnt;
      int seen;
      in_data   = 64'h0123_4567_89AB_CDEF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0 || chk_err !== 1'b0) begin
         fails++; $display("FAIL midrst_outputs got rdy=%b vld=%b data=%h err=%b want 1 0 0 0", in_ready, out_valid, out_data, chk_err);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_valid got %0d pulses want 0", seen); end
      rst_n    = 1'b1;
      in_data  = 64'h0000_0000_0000_0021;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(cnt);
      tests++; if (cnt != 16) begin fails++; $display("FAIL midrst_fresh_latency got %0d want 16", cnt); end
      tests++; if (out_data !== 64'hAAAA_AAAA_AAAA_AA38) begin fails++; $display("FAIL midrst_fresh_data got %h want aaaaaaaaaaaaaa38", out_data); end
      @(posedge clk);
      #1;
   endtask

`ifdef PRINCE_A6_INV_SELFCHECK_EN
   task automatic test_selfcheck();
      int cnt;
      logic [63:0] tmp;
      in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // nibbles 0..4 processed; corrupt already-processed nibble 3
      repeat (5) @(posedge clk);
      #1;
      tmp = dut.work_r ^ 64'h0000_0000_0000_1000;
      force dut.work_r = tmp;
      #1;
      release dut.work_r;
      wait_out(cnt);
      tests++; if (out_valid !== 1'b1 || chk_err !== 1'b1) begin
         fails++; $display("FAIL sc_detect got vld=%b err=%b want 1 1", out_valid, chk_err);
      end
      @(posedge clk);
      #1;
      tests++; if (chk_err !== 1'b1) begin fails++; $display("FAIL sc_hold got %b want 1", chk_err); end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL sc_clear got %b want 0", chk_err); end
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_mixed();
      test_backpressure();
      test_reset_mid_run();
`ifdef PRINCE_A6_INV_SELFCHECK_EN
      test_selfcheck();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
